// File: rtl/pulse_tx_pkg.sv
// Shared definitions for the pulse transmitter: FSM encoding, 50 MHz timing
// constants and a small sizing helper.
package pulse_tx_pkg;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_DLY  = 2'd1;
  localparam logic [1:0] S_HIGH = 2'd2;
  localparam logic [1:0] S_GAP  = 2'd3;

  localparam int CYC_40NS = 2;
  localparam int CYC_1US  = 50;

  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/pulse_tx_timer.sv
// Loadable down-counter that stops at zero; zero is flagged combinationally.
module tx_timer #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         load,
  input  logic [W-1:0] load_val,
  output logic         zero
);

  logic [W-1:0] count;

  // NOTE: clocked state is always assigned with <= so every flop samples
  // the pre-edge values of its neighbours, independent of block ordering.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)
      count <= '0;
    else if (load)
      count <= load_val;
    else if (count != '0)
      count <= count - W'(1);
  end

  assign zero = (count == '0);

endmodule

// File: rtl/pulse_tx.sv
// Turns single-cycle request pulses into delayed, fixed-width external pulses
// with a guaranteed low gap; requests arriving mid-transmission are queued.
module pulse_tx
  import pulse_tx_pkg::*;
#(
  parameter int DELAY   = CYC_40NS,
  parameter int WIDTH   = CYC_1US,
  parameter int GAP     = 25,
  parameter int MAXPEND = 3
) (
  input  logic                           clk,
  input  logic                           reset_n,
  input  logic                           en,
  input  logic                           in,
  input  logic                           ovf_clr,
  output logic                           out,
  output logic                           busy,
  output logic                           ovf,
  output logic [$clog2(MAXPEND+1)-1:0]   pend
);

  localparam int TW = $clog2(max3(DELAY, WIDTH, GAP) + 1);
  localparam int PW = $clog2(MAXPEND + 1);
  localparam logic [PW-1:0] PEND_MAX = PW'(MAXPEND);

  logic [1:0]    state, state_nxt;
  logic          out_nxt, ovf_nxt, ovf_evt;
  logic [PW-1:0] pend_nxt;
  logic          tmr_load, tmr_zero, dequeue, queue_req;
  logic [TW-1:0] tmr_val;

  tx_timer #(.W(TW)) u_timer (
    .clk      (clk),
    .reset_n  (reset_n),
    .load     (tmr_load),
    .load_val (tmr_val),
    .zero     (tmr_zero)
  );

  // NOTE: every signal driven here gets a default first, so no path through
  // the case statement can leave one unassigned and infer a latch.
  always_comb begin
    state_nxt = state;
    out_nxt   = out;
    tmr_load  = 1'b0;
    tmr_val   = '0;
    dequeue   = 1'b0;
    case (state)
      S_IDLE: if (en && in) begin
        tmr_load = 1'b1;
        if (DELAY > 1) begin
          state_nxt = S_DLY;
          tmr_val   = TW'(DELAY - 1);
        end else begin
          state_nxt = S_HIGH;
          tmr_val   = TW'(WIDTH - 1);
          out_nxt   = 1'b1;
        end
      end
      S_DLY: begin
        if (!en) begin
          state_nxt = S_IDLE;
        end else if (tmr_zero) begin
          state_nxt = S_HIGH;
          tmr_load  = 1'b1;
          tmr_val   = TW'(WIDTH - 1);
          out_nxt   = 1'b1;
        end
      end
      S_HIGH: if (tmr_zero) begin
        state_nxt = S_GAP;
        tmr_load  = 1'b1;
        tmr_val   = TW'(GAP - 1);
        out_nxt   = 1'b0;
      end
      S_GAP: if (tmr_zero) begin
        // Queued pulses skip the delay phase and go straight to HIGH.
        if (en && pend != '0) begin
          state_nxt = S_HIGH;
          tmr_load  = 1'b1;
          tmr_val   = TW'(WIDTH - 1);
          out_nxt   = 1'b1;
          dequeue   = 1'b1;
        end else begin
          state_nxt = S_IDLE;
        end
      end
      default: begin
        state_nxt = S_IDLE;
        out_nxt   = 1'b0;
      end
    endcase
  end

  assign queue_req = en && in && (state != S_IDLE);

  // Dequeue is applied before the new request, so a coincident request always fits.
  always_comb begin
    pend_nxt = pend;
    ovf_evt  = 1'b0;
    if (!en) begin
      pend_nxt = '0;
    end else begin
      if (dequeue)
        pend_nxt = pend - PW'(1);
      if (queue_req) begin
        if (pend_nxt < PEND_MAX)
          pend_nxt = pend_nxt + PW'(1);
        else
          ovf_evt = 1'b1;
      end
    end
    ovf_nxt = ovf_evt ? 1'b1 : (ovf_clr ? 1'b0 : ovf);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= S_IDLE;
      out   <= 1'b0;
      pend  <= '0;
      ovf   <= 1'b0;
    end else begin
      state <= state_nxt;
      out   <= out_nxt;
      pend  <= pend_nxt;
      ovf   <= ovf_nxt;
    end
  end

  assign busy = (state != S_IDLE) || (pend != '0);

endmodule

// File: tb/tb_pulse_tx.sv
// Self-checking bench for pulse_tx: directed scenarios plus random traffic
// against a pulse-schedule reference model.
module tb_pulse_tx;

  localparam int D = 2;
  localparam int W = 4;
  localparam int G = 2;
  localparam int M = 2;

  logic       clk = 1'b0;
  logic       reset_n, en, in, ovf_clr;
  logic       out, busy, ovf;
  logic [1:0] pend;

  always #10 clk = ~clk;

  pulse_tx #(.DELAY(D), .WIDTH(W), .GAP(G), .MAXPEND(M)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .en      (en),
    .in      (in),
    .ovf_clr (ovf_clr),
    .out     (out),
    .busy    (busy),
    .ovf     (ovf),
    .pend    (pend)
  );

  int errors = 0;
  int checks = 0;

  task automatic check(input string tag, input logic [31:0] act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at t=%0t: got %0d expected %0d", tag, $time, act, exp);
    end
  endtask

  // Reference model: the current transmission is described by its capture edge,
  // rise edge and end-of-gap edge; pend and ovf are plain counters/flags.
  int n;
  bit m_active;
  int m_cap, m_r, m_e, m_pend;
  bit m_ovf;
  int pulses;
  bit prev_out;

  task automatic model_reset();
    m_active = 0;
    m_pend   = 0;
    m_ovf    = 0;
    prev_out = 0;
  endtask

  task automatic model_update(input bit i, input bit e, input bit c);
    bit was_active;
    bit deq;
    bit lost;
    was_active = m_active;
    deq  = 0;
    lost = 0;
    if (m_active && !e && n > m_cap && n <= m_r) begin
      m_active = 0;
    end else if (m_active && n == m_e) begin
      if (e && m_pend > 0) begin
        deq   = 1;
        m_cap = n;
        m_r   = n;
        m_e   = n + W + G;
      end else begin
        m_active = 0;
      end
    end
    if (!e) begin
      m_pend = 0;
    end else begin
      if (deq) m_pend--;
      if (i) begin
        if (!was_active) begin
          m_active = 1;
          m_cap    = n;
          m_r      = n + D;
          m_e      = m_r + W + G;
        end else if (m_pend < M) begin
          m_pend++;
        end else begin
          lost = 1;
        end
      end
    end
    if (lost) m_ovf = 1;
    else if (c) m_ovf = 0;
  endtask

  task automatic step(input bit i, input bit e, input bit c);
    @(negedge clk);
    in = i; en = e; ovf_clr = c;
    @(posedge clk);
    n++;
    model_update(i, e, c);
    #1;
    check("out",  out,  (m_active && n >= m_r && n < m_r + W) ? 1 : 0);
    check("busy", busy, (m_active || m_pend != 0) ? 1 : 0);
    check("pend", pend, m_pend);
    check("ovf",  ovf,  m_ovf);
    if (out && !prev_out) pulses++;
    prev_out = out;
  endtask

  task automatic idle(input int cycles);
    for (int k = 0; k < cycles; k++) step(0, 1, 0);
  endtask

  initial begin
    n = 0;
    pulses = 0;
    reset_n = 1'b0; en = 1'b0; in = 1'b0; ovf_clr = 1'b0;
    model_reset();
    #35;
    check("rst_out",  out,  0);
    check("rst_busy", busy, 0);
    check("rst_pend", pend, 0);
    check("rst_ovf",  ovf,  0);
    @(negedge clk);
    reset_n = 1'b1;

    // Single pulse
    idle(3);
    step(1, 1, 0);
    idle(10);

    // Queueing three back-to-back requests
    step(1, 1, 0); step(1, 1, 0); step(1, 1, 0);
    check("queue_pend", pend, 2);
    idle(25);

    // Overflow: four requests, three pulses, then clear
    pulses = 0;
    for (int k = 0; k < 4; k++) step(1, 1, 0);
    check("ovf_set", ovf, 1);
    check("ovf_pend", pend, 2);
    idle(30);
    check("ovf_pulses", pulses, 3);
    step(0, 1, 1);
    check("ovf_clr", ovf, 0);

    // ovf_clr coincident with an overflow
    for (int k = 0; k < 3; k++) step(1, 1, 0);
    step(1, 1, 1);
    check("ovf_clr_vs_set", ovf, 1);
    idle(30);
    step(0, 1, 1);

    // Request coincident with GAP-exit dequeue while the queue is full
    pulses = 0;
    for (int k = 0; k < 3; k++) step(1, 1, 0);
    idle(5);
    step(1, 1, 0);
    check("deq_pend", pend, 2);
    check("deq_ovf",  ovf,  0);
    idle(40);
    check("deq_pulses", pulses, 4);

    // Enable drop mid-pulse
    pulses = 0;
    step(1, 1, 0);
    step(0, 1, 0); step(0, 1, 0);
    step(0, 0, 0);
    step(1, 0, 0);
    for (int k = 0; k < 6; k++) step(0, 0, 0);
    check("endrop_busy", busy, 0);
    check("endrop_pend", pend, 0);
    idle(10);
    check("endrop_pulses", pulses, 1);

    // Asynchronous reset in the middle of HIGH
    step(1, 1, 0);
    for (int k = 0; k < 3; k++) step(0, 1, 0);
    check("pre_rst_out", out, 1);
    #9;
    reset_n = 1'b0;
    #1;
    check("async_rst_out",  out,  0);
    check("async_rst_busy", busy, 0);
    model_reset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    idle(3);
    step(1, 1, 0);
    idle(10);

    // Random traffic
    for (int k = 0; k < 800; k++)
      step($urandom_range(0, 2) == 0, $urandom_range(0, 9) != 0, $urandom_range(0, 15) == 0);
    idle(20);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
